// File: rtl/uart_ram_ctrl.sv
// uart_ram_ctrl: byte-command sequencer moving write/read bursts between uart_rx, a byte RAM and uart_tx
module uart_ram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int TIMEOUT_TICKS = 240,
  parameter logic [7:0] CMD_WR = 8'hA5,
  parameter logic [7:0] CMD_RD = 8'h5A
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              bps_clk_up,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_bits_ok,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data_o,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err_o
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_LEN, WR_DATA, RD_REQ, RD_WAIT, TX_LOAD, TX_WAIT} state_t;
  state_t state, state_n;
  logic op_rd, tx_first, timed, tmo, tx_done;
  logic [ADDR_W-1:0] addr;
  logic [7:0] len;
  logic [TW-1:0] tcnt;
  assign busy = state != IDLE;
  always_comb begin
    timed = state inside {GET_ADDR, GET_LEN, WR_DATA};
    tmo = timed && bps_clk_up && !rx_bits_ok && tcnt == TW'(TIMEOUT_TICKS - 1);
    tx_done = state == TX_WAIT && !tx_first && !tx_busy;
    state_n = state;
    if (tmo) state_n = IDLE;
    else
      case (state)
        IDLE:     state_n = rx_bits_ok && (rx_data_i == CMD_WR || rx_data_i == CMD_RD) ? GET_ADDR : IDLE;
        GET_ADDR: state_n = rx_bits_ok ? GET_LEN : GET_ADDR;
        GET_LEN:  state_n = !rx_bits_ok ? GET_LEN : rx_data_i == 8'd0 ? IDLE : op_rd ? RD_REQ : WR_DATA;
        WR_DATA:  state_n = rx_bits_ok && len == 8'd1 ? IDLE : WR_DATA;
        RD_REQ:   state_n = RD_WAIT;
        RD_WAIT:  state_n = TX_LOAD;
        TX_LOAD:  state_n = tx_busy ? TX_LOAD : TX_WAIT;
        TX_WAIT:  state_n = !tx_done ? TX_WAIT : len == 8'd1 ? IDLE : RD_REQ;
        default:  state_n = IDLE;
      endcase
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      ram_we <= 1'b0;
      tx_start <= 1'b0;
      err_o <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      tx_data_o <= '0;
      addr <= '0;
      len <= '0;
      tcnt <= '0;
      op_rd <= 1'b0;
      tx_first <= 1'b0;
    end else begin
      state <= state_n;
      ram_we <= state == WR_DATA && rx_bits_ok;
      tx_start <= state == TX_LOAD && !tx_busy;
      err_o <= tmo;
      tx_first <= state == TX_LOAD;
      tcnt <= (!timed || rx_bits_ok || state_n != state) ? '0 : tcnt + TW'(bps_clk_up);
      if (state == IDLE && rx_bits_ok) op_rd <= rx_data_i == CMD_RD;
      if (state == GET_ADDR && rx_bits_ok) addr <= rx_data_i[ADDR_W-1:0];
      // RAM address is registered ahead of RD_REQ so read data lands during RD_WAIT
      if (state == GET_LEN && rx_bits_ok) begin
        len <= rx_data_i;
        ram_addr <= addr;
      end
      if (state == WR_DATA && rx_bits_ok) begin
        ram_addr <= addr;
        ram_wdata <= rx_data_i;
        addr <= addr + 1'b1;
        len <= len - 8'd1;
      end
      if (state == RD_WAIT) tx_data_o <= ram_rdata;
      if (tx_done) begin
        addr <= addr + 1'b1;
        ram_addr <= addr + 1'b1;
        len <= len - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_ram_ctrl.sv
// tb_uart_ram_ctrl: directed checks of uart_ram_ctrl against a behavioural RAM and uart_tx
module tb_uart_ram_ctrl;
  logic sys_clk = 0, rst = 1, bps_clk_up = 0, rx_bits_ok = 0;
  logic [7:0] rx_data_i = 0, ram_wdata, ram_rdata = 0, tx_data_o;
  logic [7:0] ram_addr;
  logic ram_we, tx_start, tx_busy, busy, err_o;
  logic [7:0] mem [256];
  logic [3:0] tx_cnt = 0;
  logic [7:0] we_addr[$], we_data[$], tx_q[$];
  int err_cnt = 0, start_bad = 0, checks = 0, errors = 0;
  int nw, nt;

  uart_ram_ctrl dut (
    .sys_clk(sys_clk), .rst(rst), .bps_clk_up(bps_clk_up), .rx_data_i(rx_data_i),
    .rx_bits_ok(rx_bits_ok), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tx_start(tx_start), .tx_data_o(tx_data_o), .tx_busy(tx_busy),
    .busy(busy), .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  assign tx_busy = tx_cnt != 0;
  always @(posedge sys_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    tx_cnt <= tx_start ? 4'd6 : tx_cnt != 0 ? tx_cnt - 4'd1 : 4'd0;
  end

  always @(negedge sys_clk) begin
    if (ram_we) begin
      we_addr.push_back(ram_addr);
      we_data.push_back(ram_wdata);
    end
    if (tx_start) begin
      tx_q.push_back(tx_data_o);
      if (tx_busy) start_bad++;
    end
    if (err_o) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data_i = b;
    rx_bits_ok = 1;
    @(negedge sys_clk);
    rx_bits_ok = 0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic tick();
    @(negedge sys_clk);
    bps_clk_up = 1;
    @(negedge sys_clk);
    bps_clk_up = 0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000 && busy; i++) @(negedge sys_clk);
    chk(tag, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {ram_we, tx_start, err_o}, 0);
    chk("rst_regs", {ram_addr, ram_wdata, tx_data_o}, 0);

    send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    wait_idle("wr_idle");
    chk("wr_count", we_addr.size(), 3);
    chk("wr_addr", {we_addr[0], we_addr[1], we_addr[2]}, 24'h10_11_12);
    chk("wr_data", {we_data[0], we_data[1], we_data[2]}, 24'h11_22_33);

    send(8'h5A); send(8'h10); send(8'h03);
    wait_idle("rd_idle");
    chk("rd_count", tx_q.size(), 3);
    chk("rd_data", {tx_q[0], tx_q[1], tx_q[2]}, 24'h11_22_33);
    chk("rd_nowe", we_addr.size(), 3);

    send(8'hA5); send(8'hFE); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
    wait_idle("wrap_wr_idle");
    chk("wrap_addr", {we_addr[3], we_addr[4], we_addr[5]}, 24'hFE_FF_00);
    send(8'h5A); send(8'hFE); send(8'h03);
    wait_idle("wrap_rd_idle");
    chk("wrap_data", {tx_q[3], tx_q[4], tx_q[5]}, 24'h01_02_03);
    chk("tx_start_busy", start_bad, 0);
    chk("no_err_yet", err_cnt, 0);

    nw = we_addr.size();
    send(8'hA5); send(8'h20);
    repeat (239) tick();
    chk("tmo_before", {busy, 7'd0, err_cnt[7:0]}, 16'h8000);
    tick();
    repeat (3) @(negedge sys_clk);
    chk("tmo_err", err_cnt, 1);
    chk("tmo_busy", busy, 0);
    send(8'h37);
    chk("tmo_ign_busy", busy, 0);
    chk("tmo_nowe", we_addr.size(), nw);

    nt = tx_q.size();
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h40); send(8'h00);
    chk("len0_wr_busy", busy, 0);
    send(8'h5A); send(8'h40); send(8'h00);
    repeat (10) @(negedge sys_clk);
    chk("len0_busy", busy, 0);
    chk("len0_nowe", we_addr.size(), nw);
    chk("len0_notx", tx_q.size(), nt);

    send(8'hA5); send(8'h00); send(8'h04); send(8'hAA); send(8'hBB);
    chk("mid_we", we_addr.size(), nw + 2);
    @(negedge sys_clk);
    rst = 1;
    repeat (2) @(negedge sys_clk);
    rst = 0;
    chk("mid_rst", {busy, ram_we, tx_start, err_o, ram_addr, ram_wdata, tx_data_o}, 0);
    send(8'hCC);
    chk("mid_cc", we_addr.size(), nw + 2);
    send(8'hA5); send(8'h05); send(8'h01); send(8'h77);
    wait_idle("new_idle");
    chk("new_we", {we_addr.size() == nw + 3, we_addr[nw+2], we_data[nw+2]}, {1'b1, 8'h05, 8'h77});
    chk("final_err", err_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
